// File: rtl/ram_b_pkg.sv
// ram_b_pkg: shared constants for the ram_b_mmio data memory.
//   - mem_u_b_h_w width codes and the unsigned-load bit position
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - default address of the memory-mapped UART data register
//   - misalignment helper used by the access decoder
package ram_b_pkg;

  localparam logic [2:0] MEM_BYTE         = 3'b000;
  localparam logic [2:0] MEM_HALF         = 3'b001;
  localparam logic [2:0] MEM_WORD         = 3'b010;
  localparam int         MEM_UNSIGNED_BIT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] DEFAULT_UART_ADDR = 32'h1000_0000;

  // Word beats half when both size bits are set.
  function automatic logic is_misaligned(input logic [2:0] code, input logic [1:0] lsb);
    if (code[1]) return lsb != 2'b00;
    if (code[0]) return lsb[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the board-level UART transmitter.
//   clk_i, rst_i      clock, asynchronous active-high reset (clears all entries)
//   push_i/push_data_i  write one byte; caller guarantees the FIFO is not full
//   pop_i             consumer pop; ignored while empty
//   data_o            registered head entry
//   full_o, empty_o, count_o  occupancy
module uart_tx_fifo
  import ram_b_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [7:0]                    push_data_i,
  input  logic                          pop_i,
  output logic [7:0]                    data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  buf_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = buf_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_i};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) buf_q[i] <= 8'h00;
    end else begin
      if (push_i) buf_q[wptr_q[AW-1:0]] <= push_data_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/ram_b_mmio.sv
// ram_b_mmio: byte-addressed data memory with req/ack handshake, alignment
// checking and a memory-mapped UART transmit FIFO at UART_ADDR.
//   clka, rst            clock, asynchronous active-high reset
//   req, we, addra, dina, mem_u_b_h_w   access request (sampled in IDLE)
//   douta, ack, fault, busy             response (douta/fault valid with ack)
//   uart_tx_data/valid/ready            FIFO head to the UART transmitter
// Optional macro RAM_B_SIM_PRINT_EN: echo every popped byte to the console.
// INIT_FILE names the byte-per-line hex image handed to the memory-init flow;
// the RAM itself has no reset.
module ram_b_mmio
  import ram_b_pkg::*;
#(
  parameter int unsigned SIZE       = 512,
  parameter logic [31:0] UART_ADDR  = DEFAULT_UART_ADDR,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addra,
  input  logic [31:0] dina,
  input  logic [2:0]  mem_u_b_h_w,
  output logic [31:0] douta,
  output logic        ack,
  output logic        fault,
  output logic        busy,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int unsigned AW   = $clog2(SIZE);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      mem [SIZE];
  logic [1:0]      state_q, state_d;
  logic [31:0]     douta_q, douta_d;
  logic            fault_q, fault_d;
  logic [7:0]      pend_q, pend_d;
  logic            ram_we, push;
  logic [7:0]      push_data;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  logic [AW-1:0]   idx0, idx1, idx2, idx3;
  logic            is_word, is_half, sx, is_uart, misaligned;
  logic [31:0]     load_val;

  assign idx0       = addra[AW-1:0];
  assign idx1       = idx0 + AW'(1);
  assign idx2       = idx0 + AW'(2);
  assign idx3       = idx0 + AW'(3);
  assign is_word    = mem_u_b_h_w[1];
  assign is_half    = ~mem_u_b_h_w[1] & mem_u_b_h_w[0];
  assign sx         = ~mem_u_b_h_w[MEM_UNSIGNED_BIT];
  assign is_uart    = (addra == UART_ADDR);
  assign misaligned = is_misaligned(mem_u_b_h_w, addra[1:0]);

  always_comb begin
    if (is_word)      load_val = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
    else if (is_half) load_val = {{16{sx & mem[idx1][7]}}, mem[idx1], mem[idx0]};
    else              load_val = {{24{sx & mem[idx0][7]}}, mem[idx0]};
  end

  always_comb begin
    state_d   = state_q;
    douta_d   = douta_q;
    fault_d   = fault_q;
    pend_d    = pend_q;
    ram_we    = 1'b0;
    push      = 1'b0;
    push_data = dina[7:0];
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RESP;
          douta_d = 32'h0;
          fault_d = misaligned;
          if (misaligned) begin
            // Faulting access has no side effects.
          end else if (is_uart && we) begin
            if (fifo_full) begin
              pend_d  = dina[7:0];
              state_d = ST_WAIT;
            end else begin
              push = 1'b1;
            end
          end else if (is_uart) begin
            douta_d = {30'b0, fifo_full, fifo_empty};
          end else if (we) begin
            ram_we = 1'b1;
          end else begin
            douta_d = load_val;
          end
        end
      end
      ST_WAIT: begin
        // Registered count: a pop on this same edge frees space only next cycle.
        if (fifo_count < CntW'(FIFO_DEPTH)) begin
          push      = 1'b1;
          push_data = pend_q;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        douta_d = 32'h0;
        fault_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      douta_q <= 32'h0;
      fault_q <= 1'b0;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      douta_q <= douta_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  // Little-endian store of 1/2/4 bytes; RAM contents survive reset.
  always_ff @(posedge clka) begin
    if (ram_we) begin
      mem[idx0] <= dina[7:0];
      if (is_half || is_word) mem[idx1] <= dina[15:8];
      if (is_word) begin
        mem[idx2] <= dina[23:16];
        mem[idx3] <= dina[31:24];
      end
    end
  end

  assign douta = (state_q == ST_RESP) ? douta_q : 32'h0;
  assign fault = (state_q == ST_RESP) ? fault_q : 1'b0;
  assign ack   = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clka),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (uart_tx_ready),
    .data_o      (uart_tx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign uart_tx_valid = ~fifo_empty;

`ifdef RAM_B_SIM_PRINT_EN
  always_ff @(posedge clka) begin
    if (uart_tx_valid && uart_tx_ready) $write("%c", uart_tx_data);
  end
`else
`endif

endmodule

// File: tb/tb_ram_b_mmio.sv
module tb_ram_b_mmio;

  localparam int          SIZE  = 512;
  localparam int          DEPTH = 8;
  localparam logic [31:0] UADDR = 32'h1000_0000;

  logic        clka = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addra = '0;
  logic [31:0] dina = '0;
  logic [2:0]  code = '0;
  logic [31:0] douta;
  logic        ack, fault, busy;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] ref_mem [SIZE];

  always #5 clka = ~clka;

  ram_b_mmio #(
    .SIZE       (SIZE),
    .UART_ADDR  (UADDR),
    .FIFO_DEPTH (DEPTH),
    .INIT_FILE  ("")
  ) dut (
    .clka          (clka),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .addra         (addra),
    .dina          (dina),
    .mem_u_b_h_w   (code),
    .douta         (douta),
    .ack           (ack),
    .fault         (fault),
    .busy          (busy),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] c);
    return c[1] ? 4 : (c[0] ? 2 : 1);
  endfunction

  function automatic logic model_fault(input logic [31:0] a, input logic [2:0] c);
    return (a % nbytes(c)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    int n = nbytes(c);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(a + i) % SIZE]) << (8 * i));
    if (!c[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    for (int i = 0; i < nbytes(c); i++) ref_mem[(a + i) % SIZE] = d[8 * i +: 8];
  endtask

  // Drives one request, returns what the DUT shows one cycle after acceptance.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] c, output logic got_ack, output logic [31:0] rd,
                        output logic flt);
    @(negedge clka);
    req = 1'b1; we = w; addra = a; dina = d; code = c;
    @(posedge clka);
    @(negedge clka);
    req = 1'b0; we = 1'b0; addra = $urandom; dina = $urandom;
    got_ack = ack; rd = douta; flt = fault;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    total++;
    if ({douta, ack, fault, busy, uart_tx_valid, uart_tx_data} !== 44'h0) begin
      bad++;
      $display("FAIL reset_outputs got douta=%h ack=%b fault=%b busy=%b valid=%b data=%h want all 0",
               douta, ack, fault, busy, uart_tx_valid, uart_tx_data);
    end
    @(negedge clka); rst = 1'b0;
  endtask

  task automatic test_load_ext;
    logic a; logic [31:0] rd; logic f;
    access(1, 32'h10, 32'h8899AABB, 3'b010, a, rd, f); model_store(32'h10, 32'h8899AABB, 3'b010);
    total++; if (a !== 1'b1 || rd !== 32'h0) begin bad++;
      $display("FAIL store_word ack=%b douta=%h want ack=1 douta=0", a, rd); end
    access(0, 32'h13, 0, 3'b000, a, rd, f);
    total++; if (a !== 1'b1 || rd !== 32'hFFFFFF88 || f !== 1'b0) begin bad++;
      $display("FAIL lb_signed ack=%b douta=%h fault=%b want 1 ffffff88 0", a, rd, f); end
    access(0, 32'h12, 0, 3'b101, a, rd, f);
    total++; if (a !== 1'b1 || rd !== 32'h00008899) begin bad++;
      $display("FAIL lhu ack=%b douta=%h want 1 00008899", a, rd); end
    access(0, 32'h10, 0, 3'b001, a, rd, f);
    total++; if (rd !== 32'hFFFFAABB) begin bad++;
      $display("FAIL lh_signed douta=%h want ffffaabb", rd); end
  endtask

  task automatic test_misaligned;
    logic a; logic [31:0] rd; logic f;
    access(1, 32'h20, 32'h11223344, 3'b010, a, rd, f); model_store(32'h20, 32'h11223344, 3'b010);
    access(1, 32'h30, 32'h55667788, 3'b010, a, rd, f); model_store(32'h30, 32'h55667788, 3'b010);
    access(0, 32'h22, 0, 3'b010, a, rd, f);
    total++; if (a !== 1'b1 || f !== 1'b1 || rd !== 32'h0) begin bad++;
      $display("FAIL lw_misaligned ack=%b fault=%b douta=%h want 1 1 0", a, f, rd); end
    access(1, 32'h31, 32'hDEADBEEF, 3'b001, a, rd, f);
    total++; if (a !== 1'b1 || f !== 1'b1) begin bad++;
      $display("FAIL sh_misaligned ack=%b fault=%b want 1 1", a, f); end
    access(0, 32'h30, 0, 3'b010, a, rd, f);
    total++; if (rd !== 32'h55667788 || f !== 1'b0) begin bad++;
      $display("FAIL sh_misaligned_nowrite douta=%h fault=%b want 55667788 0", rd, f); end
    access(0, 32'h20, 0, 3'b010, a, rd, f);
    total++; if (rd !== 32'h11223344) begin bad++;
      $display("FAIL lw_fault_nowrite douta=%h want 11223344", rd); end
  endtask

  task automatic test_wrap;
    logic a; logic [31:0] rd; logic f;
    access(1, SIZE + 4, 32'hCAFEF00D, 3'b010, a, rd, f); model_store(SIZE + 4, 32'hCAFEF00D, 3'b010);
    access(0, 32'h4, 0, 3'b010, a, rd, f);
    total++; if (rd !== 32'hCAFEF00D) begin bad++;
      $display("FAIL wrap douta=%h want cafef00d", rd); end
  endtask

  task automatic test_uart_status_empty;
    logic a; logic [31:0] rd; logic f;
    access(0, UADDR, 0, 3'b010, a, rd, f);
    total++; if (a !== 1'b1 || rd !== 32'h1) begin bad++;
      $display("FAIL uart_status_empty ack=%b douta=%h want 1 00000001", a, rd); end
  endtask

  task automatic fill_fifo_stalled;
    logic a; logic [31:0] rd; logic f;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      access(1, UADDR, 32'h41 + i, 3'b010, a, rd, f);
      total++; if (a !== 1'b1 || f !== 1'b0 || rd !== 32'h0) begin bad++;
        $display("FAIL uart_store_%0d ack=%b fault=%b douta=%h want 1 0 0", i, a, f, rd); end
    end
    // Ninth store stalls in WAIT.
    @(negedge clka);
    req = 1'b1; we = 1'b1; addra = UADDR; dina = 32'h49; code = 3'b010;
    @(posedge clka);
    @(negedge clka);
    req = 1'b0; we = 1'b0; dina = 0;
    total++; if (busy !== 1'b1 || ack !== 1'b0) begin bad++;
      $display("FAIL wait_entry busy=%b ack=%b want 1 0", busy, ack); end
  endtask

  task automatic test_uart_fifo;
    logic a; logic [31:0] rd; logic f;
    fill_fifo_stalled();
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      total++; if (busy !== 1'b1 || ack !== 1'b0) begin bad++;
        $display("FAIL wait_hold_%0d busy=%b ack=%b want 1 0", i, busy, ack); end
    end
    total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin bad++;
      $display("FAIL head_A valid=%b data=%h want 1 41", uart_tx_valid, uart_tx_data); end
    uart_tx_ready = 1'b1;
    @(negedge clka);
    uart_tx_ready = 1'b0;
    total++; if (ack !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL pop_same_edge ack=%b busy=%b want 0 1", ack, busy); end
    @(negedge clka);
    total++; if (ack !== 1'b1 || fault !== 1'b0 || douta !== 32'h0) begin bad++;
      $display("FAIL wait_release ack=%b fault=%b douta=%h want 1 0 0", ack, fault, douta); end
    // FIFO is full again: 'B'..'I'.
    access(0, UADDR, 0, 3'b010, a, rd, f);
    total++; if (rd !== 32'h2) begin bad++;
      $display("FAIL uart_status_full douta=%h want 00000002", rd); end
    uart_tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(8'h42 + i)) begin bad++;
        $display("FAIL drain_%0d valid=%b data=%h want 1 %h", i, uart_tx_valid, uart_tx_data,
                 8'(8'h42 + i)); end
      @(negedge clka);
    end
    uart_tx_ready = 1'b0;
    total++; if (uart_tx_valid !== 1'b0) begin bad++;
      $display("FAIL drained_empty valid=%b want 0", uart_tx_valid); end
  endtask

  task automatic test_reset_in_wait;
    logic a; logic [31:0] rd; logic f;
    fill_fifo_stalled();
    rst = 1'b1;
    #1;
    total++; if (ack !== 1'b0 || busy !== 1'b0 || uart_tx_valid !== 1'b0) begin bad++;
      $display("FAIL reset_in_wait ack=%b busy=%b valid=%b want 0 0 0", ack, busy, uart_tx_valid); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_no_ack ack=%b want 0", ack); end
    end
    rst = 1'b0;
    access(0, 32'h10, 0, 3'b010, a, rd, f);
    total++; if (a !== 1'b1 || rd !== model_load(32'h10, 3'b010)) begin bad++;
      $display("FAIL post_reset_load ack=%b douta=%h want 1 %h", a, rd, model_load(32'h10, 3'b010)); end
  endtask

  task automatic test_random;
    logic a; logic [31:0] rd; logic f;
    logic [2:0] codes [5];
    logic [31:0] addr, data, exp;
    logic [2:0] c;
    logic w, ef;
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < SIZE / 4; i++) begin
      data = $urandom;
      access(1, 32'(4 * i), data, 3'b010, a, rd, f);
      model_store(32'(4 * i), data, 3'b010);
    end
    for (int i = 0; i < 200; i++) begin
      addr = $urandom_range(0, 2 * SIZE - 1);
      c = codes[$urandom_range(0, 4)];
      w = 1'($urandom_range(0, 1));
      data = $urandom;
      ef = model_fault(addr, c);
      exp = (ef || w) ? 32'h0 : model_load(addr, c);
      access(w, addr, data, c, a, rd, f);
      if (w && !ef) model_store(addr, data, c);
      total++; if (a !== 1'b1 || f !== ef || rd !== exp) begin bad++;
        $display("FAIL random_%0d we=%b addr=%h code=%b ack=%b fault=%b douta=%h want 1 %b %h",
                 i, w, addr, c, a, f, rd, ef, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_misaligned();
    test_wrap();
    test_uart_status_empty();
    test_uart_fifo();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
